// File: rtl/huc_pkg.sv
// Shared HuCard slot bus types and mapper constants.
package huc_pkg;

    localparam int unsigned CPU_AW  = 21;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MEM_AW  = 24;
    localparam int unsigned PAGE_AW = 19;

    typedef enum int unsigned {
        MAP_FLAT = 0,
        MAP_ADDR = 1,
        MAP_DATA = 2
    } map_mode_e;

    typedef struct packed {
        logic [CPU_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ce;
        logic              oe;
        logic              we;
    } CpuBus;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] dati;
        logic              ce;
        logic              ce2;
        logic              oe;
        logic              we;
    } MemCtrl;

    typedef struct packed {
        logic              clk;
        CpuBus             cpu;
        logic [DATA_W-1:0] rom_dato;
        logic [DATA_W-1:0] ram_dato;
    } HucIn;

    typedef struct packed {
        MemCtrl            rom;
        MemCtrl            ram;
        logic              cart_ce;
        logic [DATA_W-1:0] cart_dato;
    } HucOut;

endpackage

// File: rtl/huc_bank_reg.sv
// Bank select register: decodes the register window and loads bank_q once per
// CPU write strobe (rising edge of ce & we).
module huc_bank_reg
    import huc_pkg::*;
#(
    parameter int unsigned       MODE     = MAP_ADDR,
    parameter int unsigned       BANK_W   = 2,
    parameter logic [CPU_AW-1:0] REG_BASE = 21'h001FF0
) (
    input  logic              clk,
    input  logic              rst,
    input  CpuBus             cpu,
    output logic [BANK_W-1:0] bank_o
);

    logic              we_d;
    logic              we_q;
    logic              reg_hit;
    logic              wr_stb;
    logic [BANK_W-1:0] bank_new;
    logic [BANK_W-1:0] bank_d;
    logic [BANK_W-1:0] bank_q;

    always_comb begin
        we_d     = cpu.ce & cpu.we;
        reg_hit  = 1'b0;
        bank_new = bank_q;
        if (MODE == MAP_ADDR) begin
            reg_hit  = (cpu.addr[CPU_AW-1:BANK_W] == REG_BASE[CPU_AW-1:BANK_W]);
            bank_new = cpu.addr[BANK_W-1:0];
        end else if (MODE == MAP_DATA) begin
            reg_hit  = (cpu.addr == REG_BASE);
            bank_new = cpu.data[BANK_W-1:0];
        end
        wr_stb = we_d & ~we_q & reg_hit;
        bank_d = wr_stb ? bank_new : bank_q;
    end

    // we_q resets high so a write already asserted at reset release is not a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b1;
            bank_q <= '0;
        end else begin
            we_q   <= we_d;
            bank_q <= bank_d;
        end
    end

    assign bank_o = bank_q;

    logic unused_cpu;
    assign unused_cpu = ^{cpu.oe, cpu.data};

endmodule

// File: rtl/huc_bank.sv
// Bank-switching HuCard mapper: fixed low ROM window, banked ROM window and
// optional battery-RAM window, all combinational from the CPU bus and bank_q.
module huc_bank
    import huc_pkg::*;
#(
    parameter int unsigned       MODE     = MAP_ADDR,
    parameter int unsigned       BANK_W   = 2,
    parameter int unsigned       ROM_AW   = 22,
    parameter logic [CPU_AW-1:0] REG_BASE = 21'h001FF0,
    parameter int unsigned       RAM_EN   = 0,
    parameter logic [5:0]        RAM_BASE = 6'h10,
    parameter int unsigned       RAM_AW   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  HucIn              huc_i,
    output HucOut             huc_o,
    output logic [BANK_W-1:0] bank_o
);

    localparam int unsigned PG_W = ROM_AW - PAGE_AW;

    CpuBus             cpu;
    logic [BANK_W-1:0] bank_q;
    logic              ram_hit;
    logic              bank_hit;
    logic              fix_hit;
    logic              rom_hit;
    logic [PG_W-1:0]   page;
    logic [ROM_AW-1:0] rom_addr;

    assign cpu = huc_i.cpu;

    huc_bank_reg #(
        .MODE     (MODE),
        .BANK_W   (BANK_W),
        .REG_BASE (REG_BASE)
    ) u_reg (
        .clk    (clk),
        .rst    (rst),
        .cpu    (cpu),
        .bank_o (bank_q)
    );

    assign bank_o = bank_q;

    // RAM outranks both ROM windows, so an overlapping RAM_BASE steals the range.
    always_comb begin
        ram_hit  = (RAM_EN != 0) && (cpu.addr[CPU_AW-1:15] == RAM_BASE);
        bank_hit = 1'b0;
        fix_hit  = 1'b0;
        page     = '0;
        rom_addr = ROM_AW'(cpu.addr[PAGE_AW-1:0]);
        if (MODE == MAP_FLAT) begin
            fix_hit  = ~ram_hit & ~cpu.addr[CPU_AW-1];
            rom_addr = ROM_AW'(cpu.addr[CPU_AW-2:0]);
        end else begin
            bank_hit = ~ram_hit & (cpu.addr[CPU_AW-1:PAGE_AW] == 2'b01);
            fix_hit  = ~ram_hit & (cpu.addr[CPU_AW-1:PAGE_AW] == 2'b00);
            if (bank_hit) begin
                page     = PG_W'(bank_q) + PG_W'(1);
                rom_addr = {page, cpu.addr[PAGE_AW-1:0]};
            end
        end
        rom_hit = bank_hit | fix_hit;
    end

    always_comb begin
        huc_o          = '0;
        huc_o.rom.addr = MEM_AW'(rom_addr);
        huc_o.rom.dati = cpu.data;
        huc_o.rom.ce   = rom_hit;
        huc_o.rom.ce2  = cpu.ce;
        huc_o.rom.oe   = cpu.oe;
        huc_o.rom.we   = 1'b0;
        huc_o.ram.addr = MEM_AW'(cpu.addr[RAM_AW-1:0]);
        huc_o.ram.dati = cpu.data;
        huc_o.ram.ce   = ram_hit;
        huc_o.ram.ce2  = cpu.ce;
        huc_o.ram.oe   = cpu.oe;
        huc_o.ram.we   = cpu.we & ram_hit;
        huc_o.cart_ce  = rom_hit | ram_hit;
        huc_o.cart_dato = rom_hit ? huc_i.rom_dato : huc_i.ram_dato;
    end

    logic unused_clk;
    assign unused_clk = huc_i.clk;

endmodule

// File: doc/huc_bank.md
# huc_bank

Parametrised bank-switching HuCard mapper, successor to the standard flat mapper. Sits between the HuCard CPU bus and the cart ROM/RAM memory controllers in the HuCard slot. Adds:
- a fixed 512 KB low window;
- a register-selected 512 KB banked window (SF2-class, up to 2^BANK_W pages);
- an optional battery-RAM window.

Bank-register writes are edge-detected once per CPU write strobe.

## Interface
Parameters:
- MODE, 1 — 0: flat (no banking, ROM = addr[19:0]); 1: bank = write address low bits; 2: bank = write data low bits
- BANK_W, 2 — bank register width, 1..4
- ROM_AW, 22 — rom.addr width used; upper unused rom.addr bits driven 0
- REG_BASE, 21'h001FF0 — register window base; window spans 2^BANK_W bytes (MODE 1) or 1 byte (MODE 2)
- RAM_EN, 0 — 1 enables RAM window
- RAM_BASE, 6'h10 — RAM window base in 32 KB units (0x80000)
- RAM_AW, 15 — RAM window size log2 (≤15)

Ports:
- clk  in  1  system clock, same net as huc_i.clk
- rst  in  1  asynchronous, active-high reset
- huc_i  in  HucIn  CPU bus (cpu.addr[20:0], data, ce, oe, we) plus rom_dato/ram_dato
- huc_o  out  HucOut  rom/ram MemCtrl, cart_ce, cart_dato
- bank_o  out  BANK_W  current bank register (debug/save-state)

## Operation
- Decode on cpu.addr[20:0], priority highest first:
  - RAM: RAM_EN & addr[20:15] == RAM_BASE
  - BANK: MODE≠0 & addr[20:19] == 2'b01
  - FIX: addr[20:19] == 2'b00
  - else: no hit
- MODE 0: ROM hit = addr[20]==0, rom.addr = addr[19:0]; identical to the flat mapper.
- FIX: rom.addr = {0, addr[18:0]}.
- BANK: rom.addr = {(bank_q + 1), addr[18:0]}. Page arithmetic is ROM_AW-19 bits wide and unsigned. bank_q = 3 with BANK_W=2 gives page 4 (0x200000).
- RAM: ram.addr = addr[RAM_AW-1:0]; ram.we = cpu.we & ram.ce; ram.oe = cpu.oe.
- rom: dati = cpu.data, ce2 = cpu.ce, oe = cpu.oe, we = 0. ram.dati = cpu.data, ram.ce2 = cpu.ce.
- cart_ce = rom.ce | ram.ce. cart_dato = rom_dato if rom.ce, else ram_dato.
- Register write strobe: wr_stb = cpu.ce & cpu.we & ~we_q & reg_hit. we_q is the registered (cpu.ce & cpu.we).
  - MODE 1 reg_hit: addr[20:BANK_W] == REG_BASE[20:BANK_W]; new bank = addr[BANK_W-1:0].
  - MODE 2 reg_hit: addr == REG_BASE; new bank = cpu.data[BANK_W-1:0].
  - MODE 0: register never written; bank_q stays 0.
- Register writes do not block ROM reads. A FIX-window register address still reads ROM.
- A strobe held many cycles updates bank_q once. A second write needs we to drop for ≥1 clk.

## Timing
- Reset: bank_q = 0, bank_o = 0. we_q = 1, so a write already asserted at reset release is ignored.
- All memory-control outputs are combinational from huc_i and bank_q. They have no reset value of their own.
- Bank update: bank_q loads on the first clk edge where wr_stb = 1. A read issued in the strobe cycle uses the old bank; reads from the next cycle use the new bank.
- Write to the register and read of the BANK window in the same cycle: the read sees the old bank.
- rst asserted mid-write: bank_q clears immediately (async). No update occurs until we deasserts and reasserts after rst falls.
- RAM/BANK overlap (default RAM_BASE inside the BANK window): RAM wins and rom.ce = 0.

## Structure
- huc_pkg (existing) holds HucIn, HucOut, CpuBus, MemCtrl. Add MAP_FLAT=0, MAP_ADDR=1, MAP_DATA=2 and PAGE_AW=19.
- One sub-module, huc_bank_reg: we_q edge detector, reg_hit decode, bank_q register with async reset.
- The top level holds window decode, rom/ram muxing and cart_dato select.

## Test plan
- MODE 0, read 0x0ABCDE → rom.ce=1, rom.addr=0x0ABCDE; read 0x1xxxxx → cart_ce=0.
- MODE 1, write to 0x001FF2 (we held 4 clk), then read 0x080010 → one bank update, bank_o=2, rom.addr=0x180010; read in the strobe cycle still gives 0x080010.
- MODE 2, write data 0x03 to 0x001FF0, then 0x01 with no we gap → bank_o=3 only; after a 1-clk gap and rewrite → bank_o=1.
- RAM_EN=1, write 0x5A to 0x080123 → ram.ce=1, ram.we=1, ram.addr=0x0123, rom.ce=0; read returns ram_dato.
- Hold cpu.we=1 at reg addr across rst release → bank_o stays 0 until we drops and a fresh write occurs.
- Bank 1 selected, assert rst mid-read of 0x0C0000 → bank_o=0 asynchronously, rom.addr becomes 0x0C0000.
